// File: rtl/pd_header_buffer.sv
// pd_header_buffer: collects header bytes from the packet decoder controller.
// On new_block it copies the complete header into a shadow register. It then
// streams the shadow as big-endian 32-bit words to the hash core, and pulses
// begin_hash once the last word has been taken.
//
// Handshake: word_valid/word_out are driven from the STREAM state. A word
// transfers on a rising edge where word_valid and word_ready are both high.
// While word_valid is high and word_ready is low, word_out holds its value.
// The valid side never withdraws a word except on stop_calc or reset.
module pd_header_buffer #(
  parameter int HEADER_BYTES = 80,
  parameter int PKT1_LAST    = 63
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_data_en,
  input  logic [6:0]  i_data_sel,
  input  logic [7:0]  i_data,
  input  logic        new_block,
  input  logic        stop_calc,
  input  logic        word_ready,
  output logic        packet_done,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        begin_hash,
  output logic        busy,
  output logic        hdr_error,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_START  = 2'd2
  } state_t;

  localparam int NWORDS = HEADER_BYTES / 4;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NWORDS - 1);
  localparam logic [7:0] HB8      = 8'(HEADER_BYTES);
  localparam logic [6:0] SEL_PKT1 = 7'(PKT1_LAST);
  localparam logic [6:0] SEL_LAST = 7'(HEADER_BYTES - 1);

  state_t                    state_q, state_d;
  logic [WIDX_W-1:0]         widx_q, widx_d;
  logic [HEADER_BYTES*8-1:0] mem_q, mem_d;
  logic [HEADER_BYTES*8-1:0] shadow_q, shadow_d;
  logic [HEADER_BYTES-1:0]   wmask_q, wmask_d;
  logic                      hdr_error_q, hdr_error_d;
  logic                      capture;
  logic                      wr_ok;
  logic                      wr_bad;

  assign wr_ok  = i_data_en && ({1'b0, i_data_sel} <  HB8);
  assign wr_bad = i_data_en && ({1'b0, i_data_sel} >= HB8);

  // The controller samples this in the same cycle as the write.
  assign packet_done = i_data_en && ((i_data_sel == SEL_PKT1) || (i_data_sel == SEL_LAST));

  // FSM next state, word index, capture request and error pulse.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    capture     = 1'b0;
    hdr_error_d = wr_bad;
    case (state_q)
      ST_IDLE: begin
        if (new_block) begin
          if (&wmask_q) begin
            capture = 1'b1;
            widx_d  = '0;
            state_d = ST_STREAM;
          end else begin
            hdr_error_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (new_block) hdr_error_d = 1'b1;
        if (stop_calc) begin
          state_d = ST_IDLE;
        end else if (word_ready) begin
          if (widx_q == WIDX_LAST) state_d = ST_START;
          else                     widx_d  = widx_q + 1'b1;
        end
      end
      ST_START: begin
        if (new_block) hdr_error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte storage, write mask and shadow snapshot. A snapshot uses the
  // pre-edge mem, so a write in the capture cycle stays pending in the mask.
  always_comb begin
    mem_d    = mem_q;
    wmask_d  = wmask_q;
    shadow_d = shadow_q;
    if (capture) begin
      shadow_d = mem_q;
      wmask_d  = '0;
    end
    if (wr_ok) begin
      for (int i = 0; i < HEADER_BYTES; i++) begin
        if (i_data_sel == 7'(i)) begin
          mem_d[i*8 +: 8] = i_data;
          wmask_d[i]      = 1'b1;
        end
      end
    end
  end

  // Word mux over the shadow. Byte 4*widx goes in the most significant lane.
  always_comb begin
    word_out = '0;
    if (state_q == ST_STREAM) begin
      for (int w = 0; w < NWORDS; w++) begin
        if (widx_q == WIDX_W'(w)) begin
          word_out = {shadow_q[(4*w)*8 +: 8], shadow_q[(4*w+1)*8 +: 8],
                      shadow_q[(4*w+2)*8 +: 8], shadow_q[(4*w+3)*8 +: 8]};
        end
      end
    end
  end

  assign word_valid = (state_q == ST_STREAM);
  assign begin_hash = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);
  assign hdr_error  = hdr_error_q;
  assign dbg_state  = state_q;

  // State and storage registers; reset clears everything at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      mem_q       <= '0;
      shadow_q    <= '0;
      wmask_q     <= '0;
      hdr_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      mem_q       <= mem_d;
      shadow_q    <= shadow_d;
      wmask_q     <= wmask_d;
      hdr_error_q <= hdr_error_d;
    end
  end

endmodule

// File: tb/tb_pd_header_buffer.sv
// Bench for pd_header_buffer: directed steps with a word scoreboard.
module tb_pd_header_buffer;

  logic        clk;
  logic        n_rst;
  logic        i_data_en;
  logic [6:0]  i_data_sel;
  logic [7:0]  i_data;
  logic        new_block;
  logic        stop_calc;
  logic        word_ready;
  logic        packet_done;
  logic [31:0] word_out;
  logic        word_valid;
  logic        begin_hash;
  logic        busy;
  logic        hdr_error;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int hs_count = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  hdr_m[80];
  bit          prev_hold = 0;
  logic [31:0] prev_word = '0;

  pd_header_buffer #(.HEADER_BYTES(80), .PKT1_LAST(63)) dut (
    .clk(clk), .n_rst(n_rst), .i_data_en(i_data_en), .i_data_sel(i_data_sel),
    .i_data(i_data), .new_block(new_block), .stop_calc(stop_calc),
    .word_ready(word_ready), .packet_done(packet_done), .word_out(word_out),
    .word_valid(word_valid), .begin_hash(begin_hash), .busy(busy),
    .hdr_error(hdr_error), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops on each accepted word and checks hold under backpressure.
  always @(negedge clk) begin
    if (!n_rst || stop_calc) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(word_valid), 32'd1);
        chk("hold_word", word_out, prev_word);
      end
      if (word_valid && word_ready) begin
        hs_count++;
        if (exp_q.size() == 0) chk("extra_word_qsize", 32'(exp_q.size()), 32'd1);
        else chk("word", word_out, exp_q.pop_front());
      end
      prev_hold = word_valid && !word_ready;
      prev_word = word_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input int sel, input logic [7:0] val);
    i_data_en  = 1'b1;
    i_data_sel = 7'(sel);
    i_data     = val;
    #1;
    chk($sformatf("packet_done_sel%0d", sel), 32'(packet_done), 32'((sel == 63) || (sel == 79)));
    step();
    i_data_en = 1'b0;
  endtask

  task automatic write_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) write_byte(i, hdr_m[i]);
  endtask

  task automatic start_block(input bit expect_ok);
    if (expect_ok) begin
      for (int w = 0; w < 20; w++)
        exp_q.push_back({hdr_m[4*w], hdr_m[4*w+1], hdr_m[4*w+2], hdr_m[4*w+3]});
    end
    hs_count  = 0;
    new_block = 1'b1;
    step();
    new_block = 1'b0;
    chk("nb_hdr_error", 32'(hdr_error), 32'(!expect_ok));
    chk("nb_word_valid", 32'(word_valid), 32'(expect_ok));
    if (!expect_ok) begin
      step();
      chk("nb_err_pulse_end", 32'(hdr_error), 32'd0);
      chk("nb_rej_busy", 32'(busy), 32'd0);
    end
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
  task automatic run_stream(input int mode, output int cycles);
    bit got;
    got = 0;
    cycles = 0;
    while (!got && cycles < 200) begin
      word_ready = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
      step();
      cycles++;
      if (begin_hash) got = 1;
    end
    word_ready = 1'b1;
    chk("bh_seen", 32'(got), 32'd1);
    chk("bh_after_all_accepts", 32'(hs_count), 32'd20);
    chk("bh_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bh_valid_low", 32'(word_valid), 32'd0);
    step();
    chk("bh_pulse_end", 32'(begin_hash), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    n_rst = 1'b0; i_data_en = 0; i_data_sel = '0; i_data = '0;
    new_block = 0; stop_calc = 0; word_ready = 1'b1;
    for (int i = 0; i < 80; i++) hdr_m[i] = 8'(i);

    // Reset state
    #1;
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_out", word_out, 32'd0);
    chk("rst_begin_hash", 32'(begin_hash), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hdr_error", 32'(hdr_error), 32'd0);
    chk("rst_packet_done", 32'(packet_done), 32'd0);
    step(); step();
    n_rst = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Full header, ready always high
    write_range(0, 79);
    start_block(1);
    run_stream(0, cyc);
    chk("stream_cycles", 32'(cyc), 32'd20);

    // Backpressure
    write_range(0, 79);
    start_block(1);
    run_stream(1, cyc);

    // Incomplete header
    write_range(0, 78);
    start_block(0);
    chk("incomplete_valid", 32'(word_valid), 32'd0);
    write_byte(79, hdr_m[79]);
    start_block(1);
    run_stream(0, cyc);

    // Abort during word 7
    write_range(0, 79);
    start_block(1);
    for (int k = 0; k < 7; k++) step();
    stop_calc = 1'b1;
    step();
    stop_calc = 1'b0;
    chk("abort_valid", 32'(word_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_begin_hash", 32'(begin_hash), 32'd0);
    chk("abort_remaining", 32'(exp_q.size()), 32'd13);
    step();
    chk("abort_no_bh", 32'(begin_hash), 32'd0);
    exp_q.delete();
    start_block(0);

    // Overlap: rewrite byte 0 and new_block during STREAM
    write_range(0, 79);
    start_block(1);
    hdr_m[0] = 8'hFF;
    write_byte(0, 8'hFF);
    new_block = 1'b1;
    step();
    new_block = 1'b0;
    chk("busy_nb_err", 32'(hdr_error), 32'd1);
    chk("busy_nb_valid", 32'(word_valid), 32'd1);
    run_stream(0, cyc);

    // Bad index write, then next block carries the rewritten byte 0
    write_range(1, 79);
    write_byte(100, 8'hAA);
    chk("bad_sel_err", 32'(hdr_error), 32'd1);
    step();
    chk("bad_sel_err_end", 32'(hdr_error), 32'd0);
    start_block(1);
    chk("word0_overlap", word_out, 32'hFF010203);
    run_stream(0, cyc);

    // Async reset mid-stream at word 5
    hdr_m[0] = 8'h00;
    write_range(0, 79);
    start_block(1);
    for (int k = 0; k < 5; k++) step();
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_valid", 32'(word_valid), 32'd0);
    chk("arst_word_out", word_out, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_begin_hash", 32'(begin_hash), 32'd0);
    chk("arst_hdr_error", 32'(hdr_error), 32'd0);
    exp_q.delete();
    step();
    n_rst = 1'b1;
    step();
    chk("arst_rel_valid", 32'(word_valid), 32'd0);
    start_block(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
